// File: rtl/riscv_fetch.sv
// rtl/riscv_fetch.sv - instruction fetch: PC, credit-limited imem requests, in-order response FIFO to decode
module riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDITS = DEPTH[CW:0];

  logic [31:0]   pc_q, pc_d;
  logic          run_q;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [AW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;

  logic [31:0] tag_mem  [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic req_fire, rsp_fire, push, pop;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Buffered plus in-flight instructions never exceed DEPTH, so responses always find room.
  assign imem_req_valid = run_q && (({1'b0, outstanding_q} + {1'b0, count_q}) < CREDITS);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (count_q != '0);
  assign inst           = inst_valid ? data_mem[fifo_rd_q] : 32'h0;
  assign inst_pc        = inst_valid ? pc_mem[fifo_rd_q]   : 32'h0;

  always_comb begin
    req_fire      = imem_req_valid && imem_req_ready;
    rsp_fire      = imem_rsp_valid && (outstanding_q != '0);
    push          = rsp_fire && (discard_q == '0) && !redirect_valid;
    pop           = inst_valid && inst_ready && !redirect_valid;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    fifo_wr_d     = fifo_wr_q;
    fifo_rd_d     = fifo_rd_q;

    if (req_fire) begin
      pc_d     = pc_q + 32'd4;
      tag_wr_d = tag_wr_q + AW'(1);
    end
    if (rsp_fire) begin
      tag_rd_d = tag_rd_q + AW'(1);
      if (discard_q != '0) discard_d = discard_q - CW'(1);
    end
    case ({req_fire, rsp_fire})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if (push) fifo_wr_d = fifo_wr_q + AW'(1);
    if (pop)  fifo_rd_d = fifo_rd_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Everything still in flight after this cycle, including this cycle's request, is stale.
    if (redirect_valid) begin
      pc_d      = {redirect_pc[31:2], 2'b00};
      discard_d = outstanding_d;
      count_d   = '0;
      fifo_wr_d = '0;
      fifo_rd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      run_q         <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      run_q         <= 1'b1;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr_q] <= pc_q;
    if (push) begin
      data_mem[fifo_wr_q] <= imem_rsp_data;
      pc_mem[fifo_wr_q]   <= tag_mem[tag_rd_q];
    end
  end

endmodule

// File: tb/tb_riscv_fetch.sv
// tb/tb_riscv_fetch.sv - directed tests for riscv_fetch with an in-order memory model
`timescale 1ns/1ps
module tb_riscv_fetch;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  logic mem_hold = 1'b0;
  int   mem_lat = 1;

  logic [31:0] mq[$];
  int          mc[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] acc_pc[$];
  logic [31:0] acc_data[$];
  int          acc_cyc[$];

  always #5 clk = ~clk;

  riscv_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  // Memory model returns data = address, in order, mem_lat cycles after the handshake.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      mq.delete();
      mc.delete();
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back(imem_req_addr);
        mc.push_back(cyc);
        req_log.push_back(imem_req_addr);
        req_cyc.push_back(cyc);
      end
      if (inst_valid && inst_ready) begin
        acc_pc.push_back(inst_pc);
        acc_data.push_back(inst);
        acc_cyc.push_back(cyc);
      end
    end
    #1;
    imem_rsp_valid = 1'b0;
    if (rst_n && !mem_hold && mq.size() > 0) begin
      if (cyc - mc[0] >= mem_lat - 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mq.pop_front();
        void'(mc.pop_front());
      end
    end
  end

  task automatic clear_logs();
    req_log.delete(); req_cyc.delete();
    acc_pc.delete(); acc_data.delete(); acc_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    inst_ready = 1'b0; mem_hold = 1'b0; mem_lat = 1;
    repeat (3) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    inst_ready = 1'b1; mem_hold = 1'b0; mem_lat = 1;
    repeat (3) @(negedge clk);
    tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
    tests_run++; if (imem_req_addr !== RPC) begin tests_failed++; $display("FAIL reset_req_addr got %h exp %h", imem_req_addr, RPC); end
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
    tests_run++; if (inst !== 32'h0) begin tests_failed++; $display("FAIL reset_inst got %h exp 0", inst); end
    tests_run++; if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc); end
    clear_logs();
    rst_n = 1'b1;
    #1;
    tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL release_req_valid got %b exp 0", imem_req_valid); end
    @(negedge clk);
    tests_run++; if (imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL first_req_valid got %b exp 1", imem_req_valid); end
    tests_run++; if (imem_req_addr !== RPC) begin tests_failed++; $display("FAIL first_req_addr got %h exp %h", imem_req_addr, RPC); end
  endtask

  task automatic test_stream();
    do_reset();
    inst_ready = 1'b1;
    repeat (20) @(negedge clk);
    tests_run++;
    if (acc_pc.size() < 10 || req_cyc.size() < 1) begin
      tests_failed++; $display("FAIL stream_count got %0d exp >=10", acc_pc.size());
    end else begin
      tests_run++; if (acc_cyc[0] - req_cyc[0] != 2) begin tests_failed++; $display("FAIL stream_latency got %0d exp 2", acc_cyc[0] - req_cyc[0]); end
      for (int i = 0; i < 10; i++) begin
        tests_run++; if (acc_pc[i] !== 32'(RPC + 4*i)) begin tests_failed++; $display("FAIL stream_pc[%0d] got %h exp %h", i, acc_pc[i], 32'(RPC + 4*i)); end
        tests_run++; if (acc_data[i] !== 32'(RPC + 4*i)) begin tests_failed++; $display("FAIL stream_inst[%0d] got %h exp %h", i, acc_data[i], 32'(RPC + 4*i)); end
        if (i > 0) begin
          tests_run++; if (acc_cyc[i] - acc_cyc[i-1] != 1) begin tests_failed++; $display("FAIL stream_gap[%0d] got %0d exp 1", i, acc_cyc[i] - acc_cyc[i-1]); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    repeat (5) @(negedge clk);
    tests_run++; if (inst_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_inst_valid got %b exp 1", inst_valid); end
    tests_run++; if (inst_pc !== RPC) begin tests_failed++; $display("FAIL bp_inst_pc_a got %h exp %h", inst_pc, RPC); end
    repeat (5) @(negedge clk);
    tests_run++; if (req_log.size() != DEPTH) begin tests_failed++; $display("FAIL bp_req_count got %0d exp %0d", req_log.size(), DEPTH); end
    tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_req_valid got %b exp 0", imem_req_valid); end
    tests_run++; if (inst_pc !== RPC) begin tests_failed++; $display("FAIL bp_inst_pc_b got %h exp %h", inst_pc, RPC); end
    tests_run++; if (inst !== RPC) begin tests_failed++; $display("FAIL bp_inst got %h exp %h", inst, RPC); end
    inst_ready = 1'b1;
    repeat (15) @(negedge clk);
    tests_run++;
    if (acc_pc.size() < 8) begin
      tests_failed++; $display("FAIL bp_resume_count got %0d exp >=8", acc_pc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++; if (acc_pc[i] !== 32'(RPC + 4*i)) begin tests_failed++; $display("FAIL bp_pc[%0d] got %h exp %h", i, acc_pc[i], 32'(RPC + 4*i)); end
        if (i > 0) begin
          tests_run++; if (acc_cyc[i] - acc_cyc[i-1] != 1) begin tests_failed++; $display("FAIL bp_gap[%0d] got %0d exp 1", i, acc_cyc[i] - acc_cyc[i-1]); end
        end
      end
    end
  endtask

  task automatic test_redirect_outstanding();
    do_reset();
    inst_ready = 1'b1;
    mem_hold = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (req_log.size() != 2) begin tests_failed++; $display("FAIL redir_outstanding got %0d exp 2", req_log.size()); end
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2003;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_inst_valid got %b exp 0", inst_valid); end
    tests_run++; if (imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL redir_req_valid got %b exp 1", imem_req_valid); end
    tests_run++; if (imem_req_addr !== 32'h0000_2000) begin tests_failed++; $display("FAIL redir_req_addr got %h exp 00002000", imem_req_addr); end
    mem_hold = 1'b0;
    repeat (15) @(negedge clk);
    tests_run++;
    if (acc_pc.size() < 2) begin
      tests_failed++; $display("FAIL redir_count got %0d exp >=2", acc_pc.size());
    end else begin
      tests_run++; if (acc_pc[0] !== 32'h0000_2000) begin tests_failed++; $display("FAIL redir_pc0 got %h exp 00002000", acc_pc[0]); end
      tests_run++; if (acc_data[0] !== 32'h0000_2000) begin tests_failed++; $display("FAIL redir_inst0 got %h exp 00002000", acc_data[0]); end
      tests_run++; if (acc_pc[1] !== 32'h0000_2004) begin tests_failed++; $display("FAIL redir_pc1 got %h exp 00002004", acc_pc[1]); end
    end
  endtask

  task automatic test_redirect_collide();
    bit found;
    int rcyc;
    int j;
    do_reset();
    inst_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (k >= 6 && imem_rsp_valid && imem_req_valid) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++; $display("FAIL collide_setup got 0 exp 1");
    end else begin
      rcyc = cyc + 1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_3000;
      @(negedge clk);
      redirect_valid = 1'b0;
      tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL collide_inst_valid got %b exp 0", inst_valid); end
      tests_run++; if (imem_req_addr !== 32'h0000_3000) begin tests_failed++; $display("FAIL collide_req_addr got %h exp 00003000", imem_req_addr); end
      repeat (10) @(negedge clk);
      j = -1;
      for (int i = 0; i < acc_cyc.size(); i++) if (j < 0 && acc_cyc[i] > rcyc) j = i;
      tests_run++;
      if (j < 0 || j + 1 >= acc_pc.size()) begin
        tests_failed++; $display("FAIL collide_count got %0d exp target entries", j);
      end else begin
        tests_run++; if (acc_pc[j] !== 32'h0000_3000) begin tests_failed++; $display("FAIL collide_pc0 got %h exp 00003000", acc_pc[j]); end
        tests_run++; if (acc_cyc[j] - rcyc != 3) begin tests_failed++; $display("FAIL collide_latency got %0d exp 3", acc_cyc[j] - rcyc); end
        tests_run++; if (acc_pc[j+1] !== 32'h0000_3004) begin tests_failed++; $display("FAIL collide_pc1 got %h exp 00003004", acc_pc[j+1]); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
    do_reset();
    inst_ready = 1'b1;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    tests_run++; if (imem_req_addr !== 32'hFFFF_FFF8) begin tests_failed++; $display("FAIL wrap_req_addr got %h exp fffffff8", imem_req_addr); end
    repeat (8) @(negedge clk);
    tests_run++;
    if (req_log.size() < 3 || acc_pc.size() < 3) begin
      tests_failed++; $display("FAIL wrap_count got %0d/%0d exp >=3", req_log.size(), acc_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++; if (req_log[i] !== exp_a[i]) begin tests_failed++; $display("FAIL wrap_req[%0d] got %h exp %h", i, req_log[i], exp_a[i]); end
        tests_run++; if (acc_pc[i] !== exp_a[i]) begin tests_failed++; $display("FAIL wrap_pc[%0d] got %h exp %h", i, acc_pc[i], exp_a[i]); end
        tests_run++; if (acc_data[i] !== exp_a[i]) begin tests_failed++; $display("FAIL wrap_inst[%0d] got %h exp %h", i, acc_data[i], exp_a[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_lat = 3;
    repeat (6) @(negedge clk);
    tests_run++; if (inst_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_inst_valid got %b exp 1", inst_valid); end
    tests_run++; if (req_log.size() != DEPTH) begin tests_failed++; $display("FAIL mid_pre_reqs got %0d exp %0d", req_log.size(), DEPTH); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_inst_valid got %b exp 0", inst_valid); end
    tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_req_valid got %b exp 0", imem_req_valid); end
    tests_run++; if (imem_req_addr !== RPC) begin tests_failed++; $display("FAIL mid_req_addr got %h exp %h", imem_req_addr, RPC); end
    tests_run++; if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL mid_inst_pc got %h exp 0", inst_pc); end
    repeat (2) @(negedge clk);
    clear_logs();
    mem_lat = 1;
    inst_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin tests_failed++; $display("FAIL mid_restart got %b/%h exp 1/%h", imem_req_valid, imem_req_addr, RPC); end
    repeat (8) @(negedge clk);
    tests_run++;
    if (acc_pc.size() < 2) begin
      tests_failed++; $display("FAIL mid_count got %0d exp >=2", acc_pc.size());
    end else begin
      tests_run++; if (acc_pc[0] !== RPC) begin tests_failed++; $display("FAIL mid_pc0 got %h exp %h", acc_pc[0], RPC); end
      tests_run++; if (acc_pc[1] !== 32'(RPC + 4)) begin tests_failed++; $display("FAIL mid_pc1 got %h exp %h", acc_pc[1], 32'(RPC + 4)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_collide();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
